// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, bus acknowledge
// levels and the majority vote used by the optional line glitch filter.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Conditions one raw I2C line: 2-flop synchronizer, optional 3-sample majority
// filter (enabled by I2C_GLITCH_FILTER_EN, +2 cycles latency) and edge detect.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic w_level;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] r_hist;
  logic       r_filt;

  // A single-cycle excursion never holds two of the three votes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hist <= 2'b11;
      r_filt <= 1'b1;
    end else begin
      r_hist <= {r_hist[0], r_sync};
      r_filt <= maj3(r_sync, r_hist[0], r_hist[1]);
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target with a byte register file and a local host port. Optional SDA/SCL
// glitch filtering is selected with the I2C_GLITCH_FILTER_EN macro.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         NUM_REGS = 16,
  localparam int        AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          io_mainClk,
  input  logic          io_resetn,
  input  logic          io_i2c_sda_read,
  output logic          io_i2c_sda_write,
  input  logic          io_i2c_scl_read,
  input  logic [AW-1:0] io_host_addr,
  input  logic [7:0]    io_host_wdata,
  input  logic          io_host_we,
  output logic [7:0]    io_host_rdata,
  output logic          io_wr_strobe,
  output logic [AW-1:0] io_wr_addr,
  output logic          io_busy
);

  logic w_sda;
  logic w_sda_rise;
  logic w_sda_fall;
  logic w_scl;
  logic w_scl_rise;
  logic w_scl_fall;

  i2c_line_sync u_sda_sync (
    .i_clk   (io_mainClk),
    .i_rst_n (io_resetn),
    .i_line  (io_i2c_sda_read),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  i2c_line_sync u_scl_sync (
    .i_clk   (io_mainClk),
    .i_rst_n (io_resetn),
    .i_line  (io_i2c_scl_read),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_state_e    r_state;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_rw;
  logic          r_phase;
  logic          r_sda_out;
  logic          r_busy;
  logic          r_wr_strobe;
  logic [AW-1:0] r_wr_addr;
  logic [AW-1:0] r_ptr;
  logic [7:0]    r_host_rdata;
  logic [7:0]    r_regs [NUM_REGS];

  logic          w_start;
  logic          w_stop;
  logic [7:0]    w_rx_byte;
  logic          w_byte_done;
  logic          w_commit;
  logic [AW-1:0] w_ptr_next;

  // Both lines share the same conditioning latency, so SCL level and SDA edge align.
  assign w_start     = w_scl & w_sda_fall;
  assign w_stop      = w_scl & w_sda_rise;
  assign w_rx_byte   = {r_shift[6:0], w_sda};
  assign w_byte_done = w_scl_rise && (r_bit_cnt == 4'd7);
  assign w_commit    = (r_state == WDATA_ACK) && !r_phase && w_scl_fall && !w_start && !w_stop;
  assign w_ptr_next  = r_ptr + AW'(1);

  // r_phase: in *_ACK states, set once ACK is driven; in RACK, set when the controller ACKed.
  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_phase     <= 1'b0;
      r_sda_out   <= I2C_NACK;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_ptr       <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_stop) begin
        r_state   <= IDLE;
        r_sda_out <= I2C_NACK;
        r_busy    <= 1'b0;
        r_phase   <= 1'b0;
      end else if (w_start) begin
        r_state   <= ADDR;
        r_bit_cnt <= '0;
        r_sda_out <= I2C_NACK;
        r_phase   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
          end
          ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_byte_done) begin
                if (w_rx_byte[7:1] == DEV_ADDR) begin
                  r_state <= ADDR_ACK;
                  r_rw    <= w_rx_byte[0];
                  r_phase <= 1'b0;
                  r_busy  <= 1'b1;
                end else begin
                  r_state <= IDLE;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_out <= I2C_ACK;
                r_phase   <= 1'b1;
              end else begin
                r_phase   <= 1'b0;
                r_bit_cnt <= '0;
                if (r_rw) begin
                  r_shift   <= r_regs[r_ptr];
                  r_sda_out <= r_regs[r_ptr][7];
                  r_state   <= RDATA;
                end else begin
                  r_sda_out <= I2C_NACK;
                  r_state   <= PTR;
                end
              end
            end
          end
          PTR: begin
            if (w_scl_rise) begin
              r_shift   <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_byte_done) begin
                r_ptr   <= w_rx_byte[AW-1:0];
                r_state <= PTR_ACK;
                r_phase <= 1'b0;
              end
            end
          end
          PTR_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_out <= I2C_ACK;
                r_phase   <= 1'b1;
              end else begin
                r_sda_out <= I2C_NACK;
                r_phase   <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= WDATA;
              end
            end
          end
          WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_byte_done) begin
                r_state <= WDATA_ACK;
                r_phase <= 1'b0;
              end
            end
          end
          WDATA_ACK: begin
            if (w_commit) begin
              r_sda_out   <= I2C_ACK;
              r_phase     <= 1'b1;
              r_wr_strobe <= 1'b1;
              r_wr_addr   <= r_ptr;
              r_ptr       <= w_ptr_next;
            end else if (w_scl_fall) begin
              r_sda_out <= I2C_NACK;
              r_phase   <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= WDATA;
            end
          end
          RDATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_out <= I2C_NACK;
                r_phase   <= 1'b0;
                r_state   <= RACK;
              end else begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_sda_out <= r_shift[6];
              end
            end
          end
          RACK: begin
            if (w_scl_rise) begin
              if (w_sda == I2C_NACK) begin
                r_state <= IDLE;
              end else begin
                r_phase <= 1'b1;
              end
            end else if (w_scl_fall && r_phase) begin
              r_ptr     <= w_ptr_next;
              r_shift   <= r_regs[w_ptr_next];
              r_sda_out <= r_regs[w_ptr_next][7];
              r_bit_cnt <= '0;
              r_phase   <= 1'b0;
              r_state   <= RDATA;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // The I2C commit is written last so it overrides a same-index host write.
  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_host_rdata <= '0;
    end else begin
      r_host_rdata <= r_regs[io_host_addr];
      if (io_host_we) begin
        r_regs[io_host_addr] <= io_host_wdata;
      end
      if (w_commit) begin
        r_regs[r_ptr] <= r_shift;
      end
    end
  end

  assign io_i2c_sda_write = r_sda_out;
  assign io_host_rdata    = r_host_rdata;
  assign io_wr_strobe     = r_wr_strobe;
  assign io_wr_addr       = r_wr_addr;
  assign io_busy          = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Randomised bench for i2c_target: bus-level controller tasks, a register-file
// reference model and a write-strobe scoreboard drained by a monitor process.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam logic [6:0] DEV = 7'h42;
  localparam int N  = 16;
  localparam int AW = 4;
  localparam int Q  = 8;
`ifdef I2C_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          c_scl;
  logic          c_sda;
  logic          sda_bus;
  logic          dut_sda;
  logic [AW-1:0] h_addr;
  logic [7:0]    h_wdata;
  logic          h_we;
  logic [7:0]    host_rdata;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic          busy;

  assign sda_bus = c_sda & dut_sda;

  i2c_target #(.DEV_ADDR(DEV), .NUM_REGS(N)) dut (
    .io_mainClk       (clk),
    .io_resetn        (resetn),
    .io_i2c_sda_read  (sda_bus),
    .io_i2c_sda_write (dut_sda),
    .io_i2c_scl_read  (c_scl),
    .io_host_addr     (h_addr),
    .io_host_wdata    (h_wdata),
    .io_host_we       (h_we),
    .io_host_rdata    (host_rdata),
    .io_wr_strobe     (wr_strobe),
    .io_wr_addr       (wr_addr),
    .io_busy          (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] m_regs [N];
  int         exp_wr [$];
  logic [7:0] wbuf [8];

  logic mon_en = 1'b0;
  logic low_seen = 1'b0;
  logic busy_seen = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the next expected commit index.
  always @(negedge clk) begin
    int e;
    if (resetn && wr_strobe) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_strobe: unexpected pulse at addr %0d, expected none", wr_addr);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", int'(wr_addr), e);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (!dut_sda) low_seen <= 1'b1;
      if (busy) busy_seen <= 1'b1;
    end
  end

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    c_sda = 1'b1; qwait();
    c_scl = 1'b1; qwait();
    c_sda = 1'b0; qwait();
    c_scl = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    c_sda = 1'b0; qwait();
    c_scl = 1'b1; qwait();
    c_sda = 1'b1; qwait();
    qwait();
  endtask

  task automatic bus_bit(input logic b, input bit glitch, output logic s);
    c_sda = b; qwait();
    if (glitch) begin
      c_scl = 1'b1;
      @(negedge clk);
      c_scl = 1'b0;
      qwait();
    end
    c_scl = 1'b1; qwait();
    s = sda_bus; qwait();
    c_scl = 1'b0; qwait();
  endtask

  task automatic byte_write(input logic [7:0] b, input int gbit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], (i == gbit), s);
    bus_bit(1'b1, 1'b0, ack);
  endtask

  task automatic byte_read(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    bus_bit(mack, 1'b0, s);
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    h_addr = AW'(a); h_wdata = d; h_we = 1'b1;
    @(negedge clk);
    h_we = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic host_read(input int a, output logic [7:0] d);
    h_addr = AW'(a);
    @(negedge clk);
    @(negedge clk);
    d = host_rdata;
  endtask

  // Write transaction: pointer byte then n data bytes from wbuf.
  task automatic i2c_write(input logic [7:0] ptr, input int n, input int gbit);
    logic ack;
    int p;
    bus_start();
    byte_write({DEV, 1'b0}, -1, ack); chk("wr_addr_ack", ack, 0);
    byte_write(ptr, -1, ack);         chk("wr_ptr_ack", ack, 0);
    p = ptr % N;
    for (int i = 0; i < n; i++) begin
      m_regs[p] = wbuf[i];
      exp_wr.push_back(p);
      byte_write(wbuf[i], (i == 0) ? gbit : -1, ack);
      chk("wr_data_ack", ack, 0);
      p = (p + 1) % N;
    end
    bus_stop();
    chk("busy_after_stop", busy, 0);
  endtask

  // Pointer write, repeated START, n-byte read ACKing all but the last.
  task automatic i2c_read(input logic [7:0] ptr, input int n);
    logic ack;
    logic [7:0] d;
    int p;
    bus_start();
    byte_write({DEV, 1'b0}, -1, ack); chk("rd_waddr_ack", ack, 0);
    byte_write(ptr, -1, ack);         chk("rd_ptr_ack", ack, 0);
    bus_start();
    byte_write({DEV, 1'b1}, -1, ack); chk("rd_raddr_ack", ack, 0);
    p = ptr % N;
    for (int i = 0; i < n; i++) begin
      byte_read((i == n - 1), d);
      chk("rd_byte", d, m_regs[(p + i) % N]);
    end
    chk("sda_released_after_nack", dut_sda, 1);
    chk("busy_during_read", busy, 1);
    bus_stop();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic ack;
    logic s;
    int p, n;

    resetn = 1'b0; c_scl = 1'b1; c_sda = 1'b1;
    h_addr = '0; h_wdata = '0; h_we = 1'b0;
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    chk("rst_sda", dut_sda, 1);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", host_rdata, 0);
    host_read(N - 1, d); chk("rst_reg_last", d, 0);

    // Directed write of two bytes at pointer 3.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    i2c_write(8'h03, 2, -1);
    host_read(3, d); chk("w_reg3", d, 8'hA5);
    host_read(4, d); chk("w_reg4", d, 8'h5A);

    // Pointer wrap at the top of the register file.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    i2c_write(8'h0F, 2, -1);
    host_read(15, d); chk("wrap_reg15", d, 8'h11);
    host_read(0, d);  chk("wrap_reg0", d, 8'h22);

    // Foreign address must be ignored entirely.
    low_seen = 1'b0; busy_seen = 1'b0; mon_en = 1'b1;
    bus_start();
    byte_write({7'h43, 1'b0}, -1, ack); chk("foreign_addr_nack", ack, 1);
    byte_write(8'h55, -1, ack);         chk("foreign_data_nack", ack, 1);
    bus_stop();
    mon_en = 1'b0;
    @(negedge clk);
    chk("foreign_sda_never_low", low_seen, 0);
    chk("foreign_busy_never_high", busy_seen, 0);

    // Repeated-START read of the two bytes written above.
    i2c_read(8'h03, 2);

    // Host write and I2C commit to index 5 in the same cycle.
    bus_start();
    byte_write({DEV, 1'b0}, -1, ack); chk("coll_addr_ack", ack, 0);
    byte_write(8'h05, -1, ack);       chk("coll_ptr_ack", ack, 0);
    m_regs[5] = 8'h99;
    exp_wr.push_back(5);
    d = 8'h99;
    for (int i = 7; i >= 1; i--) bus_bit(d[i], 1'b0, s);
    c_sda = d[0]; qwait();
    c_scl = 1'b1; qwait(); qwait();
    c_scl = 1'b0;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    h_addr = 4'd5; h_wdata = 8'h77; h_we = 1'b1;
    @(negedge clk);
    h_we = 1'b0;
    qwait();
    bus_bit(1'b1, 1'b0, ack); chk("coll_data_ack", ack, 0);
    bus_stop();
    host_read(5, d); chk("coll_i2c_wins", d, 8'h99);

    // Randomised writes and reads against the model.
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) host_write($urandom_range(0, N - 1), 8'($urandom));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      i2c_write(8'($urandom_range(0, 255)), n, -1);
      i2c_read(8'($urandom_range(0, 255)), $urandom_range(1, 3));
      p = $urandom_range(0, N - 1);
      host_read(p, d); chk("rand_host_read", d, m_regs[p]);
    end

`ifdef I2C_GLITCH_FILTER_EN
    wbuf[0] = 8'hC3;
    i2c_write(8'h07, 1, 3);
    host_read(7, d); chk("glitch_byte_intact", d, 8'hC3);
`endif

    // Reset asserted while the target is driving a read bit low.
    host_write(9, 8'h00);
    bus_start();
    byte_write({DEV, 1'b0}, -1, ack); chk("mr_waddr_ack", ack, 0);
    byte_write(8'h09, -1, ack);       chk("mr_ptr_ack", ack, 0);
    bus_start();
    byte_write({DEV, 1'b1}, -1, ack); chk("mr_raddr_ack", ack, 0);
    chk("mr_msb_driven_low", dut_sda, 0);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_sda_released", dut_sda, 1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
    low_seen = 1'b0; busy_seen = 1'b0; mon_en = 1'b1;
    for (int i = 0; i < 8; i++) bus_bit(1'b1, 1'b0, s);
    bus_stop();
    mon_en = 1'b0;
    @(negedge clk);
    chk("mr_bus_ignored_sda", low_seen, 0);
    chk("mr_bus_ignored_busy", busy_seen, 0);
    host_read(3, d); chk("mr_regs_cleared", d, 0);
    wbuf[0] = 8'h3C;
    i2c_write(8'h02, 1, -1);
    i2c_read(8'h02, 1);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_wr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h42, meaning the 7-bit I2C target address it answers to.
REQ-002 The block SHALL have parameter NUM_REGS, default 16, meaning the register-file depth in bytes; it is a power of two from 2 to 256.
REQ-003 The block SHALL have port io_mainClk, input, 1 bit: the single clock, sampled on the rising edge.
REQ-004 The block SHALL have port io_resetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port io_i2c_sda_read, input, 1 bit: raw SDA pin level, asynchronous.
REQ-006 The block SHALL have port io_i2c_sda_write, output, 1 bit, open-drain: 0 drives SDA low, 1 releases it.
REQ-007 The block SHALL have port io_i2c_scl_read, input, 1 bit: raw SCL pin level, asynchronous.
REQ-008 The block SHALL have port io_host_addr, input, log2(NUM_REGS) bits: local register index.
REQ-009 The block SHALL have port io_host_wdata, input, 8 bits: local write data.
REQ-010 The block SHALL have port io_host_we, input, 1 bit: local write strobe.
REQ-011 The block SHALL have port io_host_rdata, output, 8 bits: register contents at io_host_addr, registered with 1-cycle latency.
REQ-012 The block SHALL have port io_wr_strobe, output, 1 bit: one-cycle pulse when an I2C write commits a byte.
REQ-013 The block SHALL have port io_wr_addr, output, log2(NUM_REGS) bits: register index of the last I2C-committed byte.
REQ-014 The block SHALL have port io_busy, output, 1 bit: high from an addressed START until STOP.

Function
REQ-015 The block SHALL pass SDA and SCL through 2-flop synchronizers, then detect rising and falling edges on the synchronized signals.
REQ-016 The block SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high; each is recognised in any state.
REQ-017 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
REQ-018 The block SHALL sample data bits on the SCL rising edge, MSB first, and change SDA only after an SCL falling edge.
REQ-019 START SHALL enter ADDR from any state, including a repeated START; the register pointer is retained.
REQ-020 In ADDR, after 8 bits, an address match SHALL go to ADDR_ACK; a mismatch SHALL go to IDLE with SDA released until the next START.
REQ-021 The block SHALL drive ACK (SDA=0) from the SCL falling edge after bit 8 to the SCL falling edge after bit 9.
REQ-022 After ADDR_ACK, R/W=0 SHALL go to PTR, and the first byte received becomes the pointer, reduced modulo NUM_REGS.
REQ-023 Subsequent write bytes SHALL be stored at the pointer in WDATA_ACK, pulse io_wr_strobe once, and then increment the pointer modulo NUM_REGS.
REQ-024 After ADDR_ACK, R/W=1 SHALL load the register at the pointer and drive its MSB on the falling edge ending ACK.
REQ-025 In RACK, a controller ACK (SDA=0) SHALL increment the pointer, then load and shift the next byte.
REQ-026 In RACK, a controller NACK SHALL release SDA and go to IDLE.
REQ-027 STOP SHALL release SDA, go to IDLE, and clear io_busy; a partial byte is discarded.
REQ-028 A host write and an I2C commit to the same index in the same cycle SHALL resolve with the I2C write winning.
REQ-029 A host write to another index in the same cycle SHALL also take effect.

Reset
REQ-030 While io_resetn=0 at a clock edge, the block SHALL set: io_i2c_sda_write=1, io_wr_strobe=0, io_wr_addr=0, io_busy=0, io_host_rdata=0, pointer=0, all registers=0, synchronizer flops=1, state=IDLE.
REQ-031 Reset asserted mid-transfer SHALL release SDA on the next edge, and the block SHALL ignore the bus until a fresh START.

Configuration
REQ-032 With I2C_GLITCH_FILTER_EN defined, each synchronized line SHALL pass through a 3-sample majority filter, adding 2 cycles of latency; single-cycle glitches are suppressed.
REQ-033 Without I2C_GLITCH_FILTER_EN, synchronized lines SHALL feed edge detection directly; all other behaviour is identical.

Structure
REQ-034 The shared package i2c_pkg SHALL hold the FSM state encoding and the constants I2C_ACK=0 and I2C_NACK=1.
REQ-035 Synchronizer, optional filter and edge detection SHALL form one sub-module, i2c_line_sync, instantiated once per line.

Verification
REQ-036 The bench SHALL check this: write to 0x42 with pointer 0x03 and data 0xA5, 0x5A, then STOP -> regs[3]=0xA5, regs[4]=0x5A, two io_wr_strobe pulses with io_wr_addr 3 then 4, and ACK on all 4 bytes.
REQ-037 The bench SHALL check this: pointer 0x0F, write 0x11, 0x22 (NUM_REGS=16) -> regs[15]=0x11, regs[0]=0x22 (wrap).
REQ-038 The bench SHALL check this: address 0x43 -> SDA never driven low, io_busy stays 0, no strobe.
REQ-039 The bench SHALL check this: write pointer 0x03, repeated START, read 0x42 for two bytes with ACK then NACK -> bytes 0xA5, 0x5A returned MSB first, SDA released after NACK.
REQ-040 The bench SHALL check this: host writes 0x77 to index 5 in the same cycle as an I2C commit of 0x99 to index 5 -> regs[5]=0x99.
REQ-041 The bench SHALL check this: a 1-cycle SCL glitch mid-byte with I2C_GLITCH_FILTER_EN defined -> byte received intact; io_resetn=0 mid-read -> SDA=1 the next cycle.
